// File: rtl/bravo_serial_pkg.sv
// bravo_serial_pkg: shared serial line timing defaults, RX state encoding and baud divisor helper
package bravo_serial_pkg;
  localparam int CLK_HZ_DEF     = 50_000_000;
  localparam int BAUD_DEF       = 9600;
  localparam int OVERSAMPLE_DEF = 16;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
  typedef enum logic [2:0] {
    RX_IDLE      = ST_IDLE,
    RX_START     = ST_START,
    RX_DATA      = ST_DATA,
    RX_STOP      = ST_STOP,
    RX_WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_t;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: divider pulsing tick once every DIV clocks, realignable via sync_clr
module baud_tick_gen #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  logic         w_wrap;
  assign w_wrap = r_cnt == W'(DIV - 1);
  assign tick   = w_wrap;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else          r_cnt <= (sync_clr || w_wrap) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: oversampling 8N1 receiver with false-start and framing-error rejection
module serial_byte_receiver
  import bravo_serial_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  rx_state_t     r_state, w_state_n;
  logic          r_rx_m, r_rx_s;
  logic          w_tick, w_start, w_last;
  logic [SW-1:0] r_smp, w_smp_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_sh, w_sh_n, w_data_n;
  logic          w_valid_n, w_ferr_n;
  assign w_start = (r_state == RX_IDLE) && !r_rx_s;
  assign busy    = r_state != RX_IDLE;
  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .sync_clr (w_start),
    .tick     (w_tick)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
    end
  // START waits half a bit to land mid start bit; later states wait a full bit
  always_comb begin
    w_state_n = r_state;
    w_smp_n   = r_smp;
    w_bit_n   = r_bit;
    w_sh_n    = r_sh;
    w_data_n  = data_out;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    w_last    = w_tick && (r_smp == ((r_state == RX_START) ? HALF_LAST : FULL_LAST));
    if (w_tick) w_smp_n = w_last ? '0 : r_smp + 1'b1;
    case (r_state)
      RX_IDLE: if (!r_rx_s) begin
        w_state_n = RX_START;
        w_smp_n   = '0;
      end
      RX_START: if (w_last) begin
        w_state_n = r_rx_s ? RX_IDLE : RX_DATA;
        w_bit_n   = '0;
      end
      RX_DATA: if (w_last) begin
        w_sh_n    = {r_rx_s, r_sh[7:1]};
        w_bit_n   = r_bit + 1'b1;
        w_state_n = (r_bit == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (w_last) begin
        w_state_n = r_rx_s ? RX_IDLE : RX_WAIT_IDLE;
        w_valid_n = r_rx_s;
        w_ferr_n  = !r_rx_s;
        w_data_n  = r_rx_s ? r_sh : data_out;
      end
      RX_WAIT_IDLE: if (r_rx_s) w_state_n = RX_IDLE;
      default: w_state_n = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state     <= RX_IDLE;
      r_smp       <= '0;
      r_bit       <= '0;
      r_sh        <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_smp       <= w_smp_n;
      r_bit       <= w_bit_n;
      r_sh        <= w_sh_n;
      data_out    <= w_data_n;
      data_valid  <= w_valid_n;
      frame_error <= w_ferr_n;
    end
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb_serial_byte_receiver: directed 8N1 frames checked with immediate assertions
module tb_serial_byte_receiver;
  localparam int OS  = 16;
  localparam int DIV = 4;
  localparam int BIT = OS * DIV;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_error, busy;
  int         n_cmp = 0, n_bad = 0;
  int         n_vpulse = 0, n_vclk = 0, n_ferr = 0, n_both = 0, cyc = 0;
  int         t_valid[$];
  logic [7:0] v_vals[$];
  logic       prev_v = 1'b0;
  logic [7:0] last_val = 8'h00;
  int         gap;
  serial_byte_receiver #(.CLK_HZ(614_400), .BAUD(9600), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (data_valid) begin
      n_vclk++;
      if (!prev_v) begin
        n_vpulse++;
        t_valid.push_back(cyc);
        v_vals.push_back(data_out);
      end
      last_val = data_out;
    end
    if (frame_error) n_ferr++;
    if (data_valid && frame_error) n_both++;
    prev_v = data_valid;
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic put_bit(input logic b);
    rx = b;
    idle(BIT);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(stop);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_not_busy(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(busy), 32'h0);
  endtask
  initial begin
    idle(5);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    idle(10 * BIT);
    chk("idle_no_valid", n_vpulse, 0);
    chk("idle_no_ferr", n_ferr, 0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_data_out", 32'(data_out), 32'h00);
    send(8'hA5, 1'b1);
    idle(BIT);
    chk("a5_pulses", n_vpulse, 1);
    chk("a5_one_clk", n_vclk, 1);
    chk("a5_value", 32'(last_val), 32'hA5);
    chk("a5_data_out", 32'(data_out), 32'hA5);
    chk("a5_no_ferr", n_ferr, 0);
    chk("a5_busy_low", 32'(busy), 32'h0);
    rx = 1'b0;
    idle(6);
    chk("glitch_busy_high", 32'(busy), 32'h1);
    idle(3 * DIV - 6);
    rx = 1'b1;
    wait_not_busy("glitch_busy_clr", 4 * BIT);
    idle(2 * BIT);
    chk("glitch_no_valid", n_vpulse, 1);
    chk("glitch_no_ferr", n_ferr, 0);
    chk("glitch_data_out", 32'(data_out), 32'hA5);
    send(8'h3C, 1'b0);
    idle(2 * BIT);
    chk("brk_ferr_once", n_ferr, 1);
    chk("brk_no_valid", n_vpulse, 1);
    chk("brk_data_hold", 32'(data_out), 32'hA5);
    chk("brk_wait_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    idle(BIT);
    chk("brk_idle_again", 32'(busy), 32'h0);
    send(8'h81, 1'b1);
    idle(BIT);
    chk("x81_pulses", n_vpulse, 2);
    chk("x81_data_out", 32'(data_out), 32'h81);
    chk("x81_ferr_still1", n_ferr, 1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(BIT);
    chk("b2b_pulses", n_vpulse, 4);
    chk("b2b_first", 32'(v_vals.size() > 2 ? v_vals[2] : 8'hEE), 32'h00);
    chk("b2b_second", 32'(v_vals.size() > 3 ? v_vals[3] : 8'hEE), 32'hFF);
    gap = (t_valid.size() > 3) ? t_valid[3] - t_valid[2] : 0;
    chk("b2b_gap", 32'(gap >= 10 * BIT - 40 && gap <= 10 * BIT + 40), 32'h1);
    put_bit(1'b0);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    rx = 1'b1;
    idle(BIT / 2);
    reset_n = 1'b0;
    idle(3);
    chk("mid_rst_data_out", 32'(data_out), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    idle(3 * BIT);
    chk("mid_rst_no_valid", n_vpulse, 4);
    chk("mid_rst_no_ferr", n_ferr, 1);
    send(8'h7E, 1'b1);
    idle(BIT);
    chk("x7e_pulses", n_vpulse, 5);
    chk("x7e_value", 32'(last_val), 32'h7E);
    chk("x7e_data_out", 32'(data_out), 32'h7E);
    chk("valid_one_clk_all", n_vclk, 5);
    chk("valid_ferr_excl", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
